// File: rtl/switch_allocator_pkg.sv
// Shared router types: port indices and flit labels.
package switch_allocator_pkg;

    localparam int PORT_NUM  = 5;
    localparam int PORT_SIZE = $clog2(PORT_NUM);

    typedef logic [PORT_SIZE-1:0] port_t;

    typedef enum logic [1:0] {
        HEAD,
        BODY,
        TAIL,
        HEADTAIL
    } flit_label_t;

    function automatic logic is_tail(flit_label_t l);
        return (l == TAIL) || (l == HEADTAIL);
    endfunction

    function automatic port_t next_port(port_t p);
        return (p == port_t'(PORT_NUM - 1)) ? '0 : port_t'(p + port_t'(1));
    endfunction

endpackage

// File: rtl/switch_allocator_round_robin_arbiter.sv
// Round-robin pick: first request at or above ptr_i, wrapping.
module round_robin_arbiter #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    int j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = W'(j);
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Separable switch allocator: per-output round-robin with wormhole lock
// and on/off flow control.
module switch_allocator
    import switch_allocator_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic [PORT_NUM-1:0]                request_i,
    input  logic [PORT_NUM-1:0][PORT_SIZE-1:0] out_port_i,
    input  logic [PORT_NUM-1:0]                tail_i,
    input  logic [PORT_NUM-1:0]                on_off_i,
    output logic [PORT_NUM-1:0]                read_o,
    output logic [PORT_NUM-1:0]                xb_valid_o,
    output logic [PORT_NUM-1:0][PORT_SIZE-1:0] xb_sel_o,
    output logic                               error_o
);

    logic [PORT_NUM-1:0]                lock_valid_q, lock_valid_d;
    port_t [PORT_NUM-1:0]               owner_q, owner_d;
    port_t [PORT_NUM-1:0]               rr_ptr_q, rr_ptr_d;
    logic                               error_q, error_d;

    logic [PORT_NUM-1:0][PORT_NUM-1:0]  arb_req;
    logic [PORT_NUM-1:0][PORT_NUM-1:0]  arb_gnt;
    port_t [PORT_NUM-1:0]               arb_idx;
    logic [PORT_NUM-1:0]                arb_any;
    logic [PORT_NUM-1:0]                grant;

    // A locked output only sees its owner; everyone else is masked out.
    always_comb begin
        arb_req = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                arb_req[o][i] = request_i[i]
                              && (out_port_i[i] == port_t'(o))
                              && (!lock_valid_q[o]
                                  || (owner_q[o] == port_t'(i)));
            end
        end
    end

    for (genvar o = 0; o < PORT_NUM; o++) begin : g_arb
        round_robin_arbiter #(
            .N (PORT_NUM)
        ) u_arb (
            .req_i (arb_req[o]),
            .ptr_i (rr_ptr_q[o]),
            .gnt_o (arb_gnt[o]),
            .idx_o (arb_idx[o]),
            .any_o (arb_any[o])
        );
    end

    always_comb begin
        grant      = '0;
        read_o     = '0;
        xb_valid_o = '0;
        xb_sel_o   = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            grant[o] = rst && arb_any[o] && on_off_i[o];
            if (grant[o]) begin
                xb_valid_o[o] = 1'b1;
                xb_sel_o[o]   = arb_idx[o];
                read_o        = read_o | arb_gnt[o];
            end
        end
    end

    always_comb begin
        lock_valid_d = lock_valid_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        error_d      = 1'b0;
        for (int o = 0; o < PORT_NUM; o++) begin
            if (grant[o]) begin
                if (tail_i[arb_idx[o]]) begin
                    lock_valid_d[o] = 1'b0;
                    rr_ptr_d[o]     = next_port(arb_idx[o]);
                end else begin
                    lock_valid_d[o] = 1'b1;
                    owner_d[o]      = arb_idx[o];
                end
            end
        end
        for (int i = 0; i < PORT_NUM; i++) begin
            if (request_i[i] && (out_port_i[i] >= port_t'(PORT_NUM))) begin
                error_d = 1'b1;
            end
        end
        // An owner must keep naming the output it holds until its tail.
        for (int o = 0; o < PORT_NUM; o++) begin
            if (lock_valid_q[o] && request_i[owner_q[o]]
                && (out_port_i[owner_q[o]] != port_t'(o))) begin
                error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lock_valid_q <= '0;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            error_q      <= 1'b0;
        end else begin
            lock_valid_q <= lock_valid_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            error_q      <= error_d;
        end
    end

    assign error_o = error_q;

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Per-router separable switch allocator with one round-robin arbiter per output port.
- Consumes switch_request_o, out_port_o and the head-flit label from every input port's buffer. Produces the read strobe that pops each buffer and the crossbar select per output.
- Holds an output for a whole packet, head to tail (wormhole lock).
- Honours downstream on/off flow control per output.

Parameters:
PORT_NUM, 5, number of router input/output ports (DLA0 plus four mesh directions)
PORT_SIZE, $clog2(PORT_NUM), width of port_t and of input-index selects

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
request_i  in  PORT_NUM  per-input switch request (buffer non-empty and in SA state)
out_port_i  in  PORT_NUM x port_t  per-input destination output port
tail_i  in  PORT_NUM  per-input: flit at buffer head is TAIL or HEADTAIL
on_off_i  in  PORT_NUM  per-output downstream readiness (1 = may send)
read_o  out  PORT_NUM  per-input pop strobe; drives the input buffer read_i
xb_valid_o  out  PORT_NUM  per-output: a flit crosses the crossbar this cycle
xb_sel_o  out  PORT_NUM x PORT_SIZE  per-output index of the granted input
error_o  out  1  registered protocol-violation flag

Behaviour:
- Clock and reset: all state updates on posedge clk. When rst==0 at a clock edge, every register takes its reset value: lock_valid[o]=0, owner[o]=0, rr_ptr[o]=0, error_o=0.
- Outputs while rst==0: read_o, xb_valid_o and xb_sel_o are all 0 combinationally.
- Request mapping: combinational. req_to[o][i] = request_i[i] & (out_port_i[i]==o).
- Unlocked output o:
  - Pick the first i with req_to[o][i], scanning from rr_ptr[o] upward with wrap-around modulo PORT_NUM.
  - If a winner exists and on_off_i[o]==1: read_o[winner]=1, xb_valid_o[o]=1, xb_sel_o[o]=winner.
  - If tail_i[winner]==0: next cycle lock_valid[o]=1 and owner[o]=winner.
  - If tail_i[winner]==1 (HEADTAIL, single flit): no lock.
- Locked output o:
  - Only owner[o] is considered; other requesters are ignored.
  - Grant when req_to[o][owner] & on_off_i[o]. On granting a tail flit, lock_valid[o] clears next cycle.
- Pointer update: on the cycle a tail flit is granted on o (locked or single-flit), rr_ptr[o] <= (granted index + 1) mod PORT_NUM. The pointer is otherwise unchanged, which gives starvation freedom.
- Flow control: on_off_i[o]==0 means no grant on o. Lock and pointer hold their values. An unlocked output does not lock.
- Grant latency: 0 cycles (combinational from request to read_o). One flit per output per cycle. At most one read_o per input, since each input names exactly one output.
- Simultaneous release and new request: the freed output is unlocked from the next cycle; the waiting request is granted that cycle with the updated pointer.
- Errors: error_o <= 1 for one cycle after any cycle with one of these, else 0. The offending cycle still arbitrates normally, except that no grant is made to an out-of-range port.
  - request_i[i] with out_port_i[i] >= PORT_NUM.
  - Owner of a locked output presenting a different out_port_i while requesting.
  - Input requesting while it is owner of another output with an unlocked destination mismatch.
- Reset mid-packet: locks drop. Input buffers are reset in the same cycle, so no dangling state remains.

Decomposition:
- Shared noc_params package holds port_t, PORT_NUM, PORT_SIZE and the flit label enum. tail_i is derived there as (flit_label==TAIL | flit_label==HEADTAIL) by the integrating router.
- One natural sub-module: round_robin_arbiter, parameterised by N. Inputs: request vector, pointer. Outputs: one-hot grant, index, any_grant.
- Instantiate round_robin_arbiter PORT_NUM times with a generate loop. Lock/pointer registers and masking stay in switch_allocator.

Test Plan:
- Reset: hold rst=0 with all request_i=1 -> read_o=0, xb_valid_o=0; after release, the first grant goes to the lowest requesting index (rr_ptr=0).
- Contention: inputs 1 and 3 each send a HEADTAIL to output 2 every cycle -> grants alternate 1,3,1,3 on xb_sel_o[2]; rr_ptr[2] becomes 2 then 4.
- Wormhole lock: input 0 sends a 4-flit packet (HEAD, BODY, BODY, TAIL) to output 4 while input 2 also requests output 4 -> input 2 gets no grant until the cycle after the TAIL pops; then input 2 is granted.
- Backpressure: mid-packet, on_off_i[4]=0 for 3 cycles -> read_o[0]=0 and the lock is held; with on_off restored, the remaining flits follow in order, no interleaving.
- Parallelism: inputs 0..4 target distinct outputs (i -> (i+1)%5) -> all five read_o=1 in the same cycle; each xb_sel_o[(i+1)%5]=i.
- Error: request with out_port_i=7 (PORT_SIZE=3) -> no read_o for that input; error_o=1 exactly one cycle later, then 0.
